// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: controller state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one Full_Adder sequenced LSB-first,
// carry held in a flip-flop, results returned over a valid/ready handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;
  logic               r_ovf;
  logic               w_accept;
  logic               w_last;
  logic               w_fa_s;
  logic               w_fa_co;
  logic               w_c_msb;

  Full_Adder u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_fa_s),
    .co (w_fa_co)
  );

  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  // On the last bit the carry FF holds the carry into the MSB.
  assign w_c_msb = r_carry;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      BUSY: if (w_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? BUSY : IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_accept = in_valid && in_ready;
    if (w_accept) w_next = BUSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and force the carry-in.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub | ci;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_s     <= {w_fa_s, r_s[WIDTH-1:1]};
      r_carry <= w_fa_co;
      if (w_last) begin
        r_cnt <= '0;
        r_co  <= w_fa_co;
        r_ovf <= w_c_msb ^ w_fa_co;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule
